// File: rtl/fifo_pkg.sv
// Shared types and sizes for both sides of the single-clock FIFO.
// Pointers carry one extra wrap bit above the RAM address.
package fifo_pkg;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 2**AW;

    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle: writer pointer and flush in, RAM read port, consumer stream.
// master = read controller, slave = the surrounding FIFO/consumer environment.
interface fifo_read_ctrl_if;
    import fifo_pkg::*;

    ptr_t  W_ptr;
    logic  Flush;
    logic  R_en;
    addr_t R_addr;
    data_t R_data;
    ptr_t  R_ptr;
    logic  Empty;
    ptr_t  Count;
    data_t Dout;
    logic  Dout_valid;
    logic  Dout_ready;

    modport master (
        input  W_ptr, Flush, R_data, Dout_ready,
        output R_en, R_addr, R_ptr, Empty, Count, Dout, Dout_valid
    );

    modport slave (
        output W_ptr, Flush, R_data, Dout_ready,
        input  R_en, R_addr, R_ptr, Empty, Count, Dout, Dout_valid
    );
endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer; head is presented on o_dout, loads the edge after push.
// Head and valid hold while not popped; flush empties it, overriding pop and push.
module fifo_out_skid
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  data_t      i_din,
    input  logic       i_pop,
    input  logic       i_flush,
    output data_t      o_dout,
    output logic       o_valid,
    output logic [1:0] o_cnt
);
    data_t      r_head;
    data_t      r_tail;
    logic [1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_din;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_head <= i_din;
                    end else if (i_push) begin
                        r_tail <= i_din;
                        r_cnt  <= 2'd2;
                    end else if (i_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                default: begin
                    // Tail moves up on pop; a same-cycle push refills the tail.
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= i_din;
                        else        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_valid = (r_cnt != 2'd0);
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: owns the read pointer, issues RAM reads, FWFT output stream.
// Two cycles from W_ptr change to Dout_valid; at most 2 words leave RAM under backpressure.
module fifo_read_ctrl
    import fifo_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    fifo_read_ctrl_if.master io_rd
);
    ptr_t       r_ptr;
    logic       r_rd_pend;
    logic [1:0] w_buf_cnt;
    logic [2:0] w_occ;
    logic       w_dout_valid;
    logic       w_pop;
    logic       w_empty;
    logic       w_issue;
    logic       w_push;

    assign w_pop   = w_dout_valid & io_rd.Dout_ready;
    assign w_empty = (r_ptr == io_rd.W_ptr);
    // Words the buffer will hold after this edge, before counting a new issue.
    assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue = rst_n & ~w_empty & ~io_rd.Flush & (w_occ <= 3'd1);
    assign w_push  = r_rd_pend & ~io_rd.Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_rd_pend <= 1'b0;
        end else if (io_rd.Flush) begin
            r_ptr     <= io_rd.W_ptr;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_issue) r_ptr <= r_ptr + 1'b1;
        end
    end

    fifo_out_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (io_rd.R_data),
        .i_pop   (w_pop),
        .i_flush (io_rd.Flush),
        .o_dout  (io_rd.Dout),
        .o_valid (w_dout_valid),
        .o_cnt   (w_buf_cnt)
    );

    assign io_rd.R_en       = w_issue;
    assign io_rd.R_addr     = r_ptr[AW-1:0];
    assign io_rd.R_ptr      = r_ptr;
    assign io_rd.Empty      = w_empty;
    assign io_rd.Count      = io_rd.W_ptr - r_ptr;
    assign io_rd.Dout_valid = w_dout_valid;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: RAM model, directed latency/backpressure/wrap/flush/reset cases,
// and a random phase scored against a pointer-and-memory reference of the FIFO contents.
module tb_fifo_read_ctrl;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_read_ctrl_if bus();

    fifo_read_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_rd (bus)
    );

    data_t mem [DEPTH];
    always @(posedge clk) if (bus.R_en) bus.R_data <= mem[bus.R_addr];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    ptr_t m_rptr   = '0;   // reference: next word to be fetched from RAM
    ptr_t m_pop    = '0;   // reference: next word the consumer should receive

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        ptr_t p;
        p = bus.W_ptr;
        for (int i = 0; i < n; i++) begin
            mem[p[AW-1:0]] = data_t'($urandom);
            p = p + 1'b1;
        end
        bus.W_ptr = p;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.Dout_ready = 1'b1;
        while (m_pop != bus.W_ptr && k < 60) begin
            step();
            k++;
        end
        check_eq("drain_timeout", 32'(k < 60), 32'd1);
        step();
    endtask

    // Reference scoreboard: every fetch must hit the next unread address, every pop
    // must deliver the next written word, and no more than two words may be in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                check_eq("m_rptr",  32'(bus.R_ptr), 32'(m_rptr));
                check_eq("m_empty", 32'(bus.Empty), 32'(m_rptr == bus.W_ptr));
                check_eq("m_count", 32'(bus.Count), 32'(ptr_t'(bus.W_ptr - m_rptr)));
                if (bus.Flush) check_eq("m_flush_ren", 32'(bus.R_en), 32'd0);
                if (bus.R_en) begin
                    check_eq("m_raddr", 32'(bus.R_addr), 32'(m_rptr[AW-1:0]));
                    m_rptr = m_rptr + 1'b1;
                end
                if (bus.Dout_valid && bus.Dout_ready) begin
                    check_eq("m_data", 32'(bus.Dout), 32'(mem[m_pop[AW-1:0]]));
                    m_pop = m_pop + 1'b1;
                end
                check_eq("m_inflight", 32'(ptr_t'(m_rptr - m_pop) <= ptr_t'(2)), 32'd1);
                if (bus.Flush) begin
                    m_rptr = bus.W_ptr;
                    m_pop  = bus.W_ptr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int    first, last, nv, nren;
        ptr_t  p0;
        data_t held;
        addr_t addrs [4];

        bus.W_ptr      = '0;
        bus.Flush      = 1'b0;
        bus.Dout_ready = 1'b0;

        // Asynchronous reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ren",   32'(bus.R_en),       32'd0);
        check_eq("rst_dv",    32'(bus.Dout_valid), 32'd0);
        check_eq("rst_dout",  32'(bus.Dout),       32'd0);
        check_eq("rst_rptr",  32'(bus.R_ptr),      32'd0);
        check_eq("rst_empty", 32'(bus.Empty),      32'd1);
        check_eq("rst_count", 32'(bus.Count),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // First word latency
        bus.Dout_ready = 1'b1;
        step();
        push_words(1);
        @(negedge clk);
        check_eq("lat_ren",    32'(bus.R_en),   32'd1);
        check_eq("lat_raddr",  32'(bus.R_addr), 32'd0);
        @(negedge clk);
        check_eq("lat_ren_off", 32'(bus.R_en),       32'd0);
        check_eq("lat_dv_e1",   32'(bus.Dout_valid), 32'd0);
        check_eq("lat_rptr",    32'(bus.R_ptr),      32'd1);
        check_eq("lat_empty",   32'(bus.Empty),      32'd1);
        @(negedge clk);
        check_eq("lat_dv_e2",   32'(bus.Dout_valid), 32'd1);
        check_eq("lat_dout",    32'(bus.Dout),       32'(mem[0]));
        drain();

        // Five words at full throughput
        step();
        push_words(5);
        first = -1; last = -1; nv = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.Dout_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        check_eq("tput_words", 32'(nv), 32'd5);
        check_eq("tput_span",  32'(last - first), 32'd4);
        drain();

        // Backpressure: only two reads leave RAM, head holds still
        bus.Dout_ready = 1'b0;
        step();
        p0 = bus.W_ptr;
        push_words(4);
        nren = 0;
        held = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.R_en) nren++;
            if (c == 2) held = bus.Dout;
        end
        check_eq("bp_ren_pulses", 32'(nren),           32'd2);
        check_eq("bp_count",      32'(bus.Count),      32'd2);
        check_eq("bp_dv",         32'(bus.Dout_valid), 32'd1);
        check_eq("bp_dout_head",  32'(held),           32'(mem[p0[AW-1:0]]));
        check_eq("bp_dout_stable", 32'(bus.Dout),      32'(held));
        step();
        bus.Dout_ready = 1'b1;
        first = -1; last = -1; nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.Dout_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        check_eq("bp_release_words", 32'(nv), 32'd4);
        check_eq("bp_release_span",  32'(last - first), 32'd3);
        drain();

        // Pointer wrap: position the reader just below the wrap with a flush
        step();
        bus.W_ptr = ptr_t'(11'h3FE);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        push_words(3);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.R_en && nv < 4) begin
                addrs[nv] = bus.R_addr;
                nv++;
            end
        end
        check_eq("wrap_reads", 32'(nv),       32'd3);
        check_eq("wrap_addr0", 32'(addrs[0]), 32'h3FE);
        check_eq("wrap_addr1", 32'(addrs[1]), 32'h3FF);
        check_eq("wrap_addr2", 32'(addrs[2]), 32'h000);
        drain();
        check_eq("wrap_rptr",  32'(bus.R_ptr), 32'h401);
        check_eq("wrap_empty", 32'(bus.Empty), 32'd1);

        // Flush with words buffered and a read in flight, then with a full buffer
        for (int w = 2; w <= 4; w += 2) begin
            bus.Dout_ready = 1'b0;
            step();
            p0 = bus.W_ptr;
            push_words(4);
            repeat (w) step();
            bus.Flush = 1'b1;
            @(negedge clk);
            check_eq("flush_ren", 32'(bus.R_en), 32'd0);
            step();
            bus.Flush = 1'b0;
            @(negedge clk);
            check_eq("flush_dv",    32'(bus.Dout_valid), 32'd0);
            check_eq("flush_rptr",  32'(bus.R_ptr),      32'(ptr_t'(p0 + 4)));
            check_eq("flush_count", 32'(bus.Count),      32'd0);
            check_eq("flush_empty", 32'(bus.Empty),      32'd1);
            @(negedge clk);
            check_eq("flush_no_stale", 32'(bus.Dout_valid), 32'd0);
        end

        // Random traffic, backpressure and occasional flushes
        for (int c = 0; c < 400; c++) begin
            step();
            bus.Dout_ready = 1'($urandom_range(0, 1));
            bus.Flush      = ($urandom_range(0, 39) == 0);
            if (!bus.Flush && $urandom_range(0, 2) == 0 && ptr_t'(bus.W_ptr - m_pop) < ptr_t'(32))
                push_words(int'($urandom_range(1, 3)));
        end
        step();
        bus.Flush = 1'b0;
        drain();

        // Reset in the middle of a stalled stream
        bus.Dout_ready = 1'b0;
        step();
        push_words(3);
        repeat (3) step();
        @(negedge clk);
        #2;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        bus.W_ptr = '0;
        #1;
        check_eq("mrst_dv",    32'(bus.Dout_valid), 32'd0);
        check_eq("mrst_ren",   32'(bus.R_en),       32'd0);
        check_eq("mrst_rptr",  32'(bus.R_ptr),      32'd0);
        check_eq("mrst_dout",  32'(bus.Dout),       32'd0);
        check_eq("mrst_empty", 32'(bus.Empty),      32'd1);
        check_eq("mrst_count", 32'(bus.Count),      32'd0);
        m_rptr = '0;
        m_pop  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
        bus.Dout_ready = 1'b1;
        push_words(2);
        drain();
        check_eq("post_rst_rptr", 32'(bus.R_ptr), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
